fifo_mem_responder: RTL and testbench



---
 rtl/fifo_if_pkg.sv | 24 ++
 rtl/fifo_mem_responder_if.sv | 27 ++
 rtl/fifo_mem_bank.sv | 33 +++
 rtl/fifo_mem_responder.sv | 128 ++++++++++++
 tb/tb_fifo_mem_responder.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_if_pkg.sv
// Shared definitions for the fifo cache command/response interface.
package fifo_if_pkg;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  localparam int FIFO_DATA_W  = 128;
  localparam int FIFO_MASK_W  = 16;
  localparam int FIFO_ADDR_W  = 27;
  localparam int FIFO_BURST_W = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_WAIT = 2'd2,
    RD      = 2'd3
  } state_t;

  // The wire mask marks bytes to skip; the RAM wants bytes to write.
  function automatic logic [FIFO_MASK_W-1:0] mask_to_be(input logic [FIFO_MASK_W-1:0] mask);
    return ~mask;
  endfunction

endpackage

// File: rtl/fifo_mem_responder_if.sv
// Command/response bundle between the cache (master) and the memory responder (slave).
interface fifo_mem_responder_if
  import fifo_if_pkg::*;
#(
  parameter int ADDR_W = FIFO_ADDR_W
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_type;
  logic [ADDR_W-1:0]       cmd_addr;
  logic [FIFO_BURST_W-1:0] cmd_burst_cnt;
  logic [FIFO_DATA_W-1:0]  cmd_wt_data;
  logic [FIFO_MASK_W-1:0]  cmd_wt_mask;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [FIFO_DATA_W-1:0]  rsp_data;

  modport master (
    output cmd_valid, cmd_type, cmd_addr, cmd_burst_cnt, cmd_wt_data, cmd_wt_mask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_addr, cmd_burst_cnt, cmd_wt_data, cmd_wt_mask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/fifo_mem_bank.sv
// DEPTH x 128 single-port synchronous RAM with byte enables and a one-cycle read.
module fifo_mem_bank
  import fifo_if_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   we,
  input  logic [IDX_W-1:0]       addr,
  input  logic [FIFO_MASK_W-1:0] be,
  input  logic [FIFO_DATA_W-1:0] wdata,
  output logic [FIFO_DATA_W-1:0] rdata
);
  logic [FIFO_DATA_W-1:0] mem [DEPTH];

  // Byte-lane writes; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int b = 0; b < FIFO_MASK_W; b++) begin
        if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Registered read port; holds its value between reads so a stalled beat stays stable.
  always_ff @(posedge clk) begin
    if (rst)            rdata <= '0;
    else if (en && !we) rdata <= mem[addr];
  end
endmodule

// File: rtl/fifo_mem_responder.sv
// Memory-side responder: services read/write bursts from an internal RAM with a fixed read latency.
module fifo_mem_responder
  import fifo_if_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 4,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input logic                 clk,
  input logic                 rst,
  fifo_mem_responder_if.slave io_fifo
);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int LAT_W  = $clog2(RD_LAT + 1);
  localparam int BEAT_W = FIFO_BURST_W + 1;

  state_t                 state;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       cmd_idx;
  logic [IDX_W-1:0]       mem_addr;
  logic [BEAT_W-1:0]      beats;
  logic [LAT_W-1:0]       lat_cnt;
  logic                   cmd_ready_q;
  logic                   rsp_valid_q;
  logic                   cmd_hs;
  logic                   rsp_hs;
  logic                   mem_we;
  logic                   rd_issue;
  logic                   mem_en;
  logic [FIFO_DATA_W-1:0] mem_rdata;
  logic                   unused_addr;

  // Only the word-index bits of the address matter; the rest are intentionally dropped.
  assign unused_addr = ^io_fifo.cmd_addr;
  assign cmd_idx     = io_fifo.cmd_addr[4 +: IDX_W];
  assign cmd_hs      = io_fifo.cmd_valid & cmd_ready_q;
  assign rsp_hs      = rsp_valid_q & io_fifo.rsp_ready;

  assign io_fifo.cmd_ready = cmd_ready_q;
  assign io_fifo.rsp_valid = rsp_valid_q;
  assign io_fifo.rsp_data  = mem_rdata;

  // RAM port steering: writes on command beats, reads on the latency expiry and on each rsp handshake.
  always_comb begin
    mem_we   = 1'b0;
    rd_issue = 1'b0;
    if (!rst) begin
      mem_we   = cmd_hs && ((state == IDLE && io_fifo.cmd_type == CMD_WRITE) || state == WR);
      rd_issue = (state == RD_WAIT && lat_cnt == LAT_W'(1)) ||
                 (state == RD && rsp_hs && beats != BEAT_W'(1));
    end
    mem_en   = mem_we | rd_issue;
    mem_addr = (state == IDLE) ? cmd_idx : idx;
  end

  fifo_mem_bank #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_bank (
    .clk   (clk),
    .rst   (rst),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (mem_addr),
    .be    (mask_to_be(io_fifo.cmd_wt_mask)),
    .wdata (io_fifo.cmd_wt_data),
    .rdata (mem_rdata)
  );

  // Control FSM; beats counts words still to deliver (read) or still to accept (write).
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      idx         <= '0;
      beats       <= '0;
      lat_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_hs) begin
            if (io_fifo.cmd_type == CMD_WRITE) begin
              if (io_fifo.cmd_burst_cnt != '0) begin
                idx   <= cmd_idx + IDX_W'(1);
                beats <= {1'b0, io_fifo.cmd_burst_cnt};
                state <= WR;
              end
            end else begin
              idx         <= cmd_idx;
              beats       <= {1'b0, io_fifo.cmd_burst_cnt} + BEAT_W'(1);
              lat_cnt     <= LAT_W'(RD_LAT);
              cmd_ready_q <= 1'b0;
              state       <= RD_WAIT;
            end
          end
        end
        WR: begin
          if (cmd_hs) begin
            idx   <= idx + IDX_W'(1);
            beats <= beats - BEAT_W'(1);
            if (beats == BEAT_W'(1)) state <= IDLE;
          end
        end
        RD_WAIT: begin
          if (lat_cnt == LAT_W'(1)) begin
            idx         <= idx + IDX_W'(1);
            rsp_valid_q <= 1'b1;
            state       <= RD;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        RD: begin
          if (rsp_hs) begin
            if (beats == BEAT_W'(1)) begin
              rsp_valid_q <= 1'b0;
              cmd_ready_q <= 1'b1;
              state       <= IDLE;
            end else begin
              idx   <= idx + IDX_W'(1);
              beats <= beats - BEAT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_mem_responder.sv
// Scoreboard bench for fifo_mem_responder: reads push expected words, rsp beats pop and compare.
module tb_fifo_mem_responder;
  import fifo_if_pkg::*;

  localparam int DEPTH  = 1024;
  localparam int RD_LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [127:0] exp_q [$];
  logic [127:0] wbuf [64];

  fifo_mem_responder_if #(.ADDR_W(27)) io_fifo ();

  fifo_mem_responder #(.DEPTH(DEPTH), .RD_LAT(RD_LAT), .ADDR_W(27)) dut (
    .clk     (clk),
    .rst     (rst),
    .io_fifo (io_fifo.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command beat and return #1 after the edge on which it was accepted.
  task automatic send_beat(input logic typ, input logic [26:0] a, input logic [5:0] bc,
                           input logic [127:0] d, input logic [15:0] m);
    int n = 0;
    io_fifo.cmd_valid     = 1'b1;
    io_fifo.cmd_type      = typ;
    io_fifo.cmd_addr      = a;
    io_fifo.cmd_burst_cnt = bc;
    io_fifo.cmd_wt_data   = d;
    io_fifo.cmd_wt_mask   = m;
    while (io_fifo.cmd_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (io_fifo.cmd_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL cmd_accept_timeout: cmd_ready=%b want 1", io_fifo.cmd_ready);
    end
    tick();
    io_fifo.cmd_valid = 1'b0;
  endtask

  // Write n beats from wbuf starting at byte address a, with gap idle cycles between beats.
  task automatic write_burst(input logic [26:0] a, input int n, input logic [15:0] m, input int gap);
    for (int i = 0; i < n; i++) begin
      send_beat(CMD_WRITE, a, 6'(n - 1), wbuf[i], m);
      if (i != n - 1) repeat (gap) tick();
    end
  endtask

  // Drain nbeats rsp beats; pat[k%4] drives rsp_ready on successive valid cycles.
  task automatic collect(input int nbeats, input logic [3:0] pat, input string tag);
    int           got   = 0;
    int           cyc   = 0;
    int           k     = 0;
    logic         stall = 1'b0;
    logic [127:0] held  = '0;
    logic [127:0] exp;
    while (got < nbeats && cyc < 400) begin
      if (stall) begin
        total++;
        if (io_fifo.rsp_valid !== 1'b1 || io_fifo.rsp_data !== held) begin
          bad++;
          $display("FAIL %s_stall_hold: valid=%b data=%h want valid=1 data=%h",
                   tag, io_fifo.rsp_valid, io_fifo.rsp_data, held);
        end
      end
      stall = 1'b0;
      if (io_fifo.rsp_valid === 1'b1) begin
        io_fifo.rsp_ready = pat[k % 4];
        k++;
        if (io_fifo.rsp_ready) begin
          exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
          total++;
          if (io_fifo.rsp_data !== exp) begin
            bad++;
            $display("FAIL %s_beat%0d: data=%h want %h", tag, got, io_fifo.rsp_data, exp);
          end
          total++;
          if (io_fifo.cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s_cmd_ready_busy: cmd_ready=%b want 0", tag, io_fifo.cmd_ready);
          end
          got++;
        end else begin
          stall = 1'b1;
          held  = io_fifo.rsp_data;
        end
      end else begin
        io_fifo.rsp_ready = 1'b0;
      end
      tick();
      cyc++;
    end
    io_fifo.rsp_ready = 1'b0;
    total++;
    if (got != nbeats) begin
      bad++;
      $display("FAIL %s_beat_count: got %0d want %0d", tag, got, nbeats);
    end
    total++;
    if (io_fifo.rsp_valid !== 1'b0 || io_fifo.cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_done: rsp_valid=%b cmd_ready=%b want 0/1", tag, io_fifo.rsp_valid, io_fifo.cmd_ready);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_leftover: %0d expected beats never arrived, want 0", tag, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total++;
    if (io_fifo.cmd_ready !== 1'b0 || io_fifo.rsp_valid !== 1'b0 || io_fifo.rsp_data !== '0) begin
      bad++;
      $display("FAIL reset_outputs: cmd_ready=%b rsp_valid=%b rsp_data=%h want 0/0/0",
               io_fifo.cmd_ready, io_fifo.rsp_valid, io_fifo.rsp_data);
    end
    rst = 1'b0;
    tick();
    total++;
    if (io_fifo.cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready: cmd_ready=%b want 1", io_fifo.cmd_ready);
    end
  endtask

  // Single write then immediate single read; also checks exact read latency.
  task automatic test_single();
    int lat = 0;
    logic [127:0] d = 128'h0123456789ABCDEF_FEDCBA9876543210;
    send_beat(CMD_WRITE, 27'h0000010, 6'd0, d, 16'h0000);
    exp_q.push_back(d);
    send_beat(CMD_READ, 27'h0000010, 6'd0, '0, '0);
    while (io_fifo.rsp_valid !== 1'b1 && lat < 50) begin
      total++;
      if (io_fifo.cmd_ready !== 1'b0) begin
        bad++;
        $display("FAIL single_wait_ready: cmd_ready=%b want 0", io_fifo.cmd_ready);
      end
      tick();
      lat++;
    end
    total++;
    if (lat != RD_LAT) begin
      bad++;
      $display("FAIL single_latency: got %0d cycles want %0d", lat, RD_LAT);
    end
    collect(1, 4'hF, "single");
  endtask

  // Burst of 4 starting two words before the end wraps to words 0 and 1.
  task automatic test_burst_wrap();
    logic [26:0] a = 27'((DEPTH - 2) * 16);
    for (int i = 0; i < 4; i++) wbuf[i] = 128'(i + 1);
    write_burst(a, 4, 16'h0000, 0);
    for (int i = 0; i < 4; i++) exp_q.push_back(128'(i + 1));
    send_beat(CMD_READ, a, 6'd3, '0, '0);
    collect(4, 4'hF, "wrap");
    exp_q.push_back(128'd3);
    exp_q.push_back(128'd4);
    send_beat(CMD_READ, 27'h0, 6'd1, '0, '0);
    collect(2, 4'hF, "wrap_low");
  endtask

  // Partial byte mask and an all-ones mask that must leave memory unchanged.
  task automatic test_mask();
    send_beat(CMD_WRITE, 27'h0000400, 6'd0, {128{1'b1}}, 16'h0000);
    send_beat(CMD_WRITE, 27'h0000400, 6'd0, '0, 16'hFF00);
    send_beat(CMD_WRITE, 27'h0000410, 6'd0, {16{8'hAA}}, 16'h0000);
    send_beat(CMD_WRITE, 27'h0000410, 6'd0, {16{8'h55}}, 16'hFFFF);
    exp_q.push_back({{8{8'hFF}}, {8{8'h00}}});
    exp_q.push_back({16{8'hAA}});
    send_beat(CMD_READ, 27'h0000400, 6'd1, '0, '0);
    collect(2, 4'hF, "mask");
  endtask

  // 8-beat read with rsp_ready stalls.
  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) wbuf[i] = {32'hB00C0000 + 32'(i), 96'h0} | 128'(i * 7 + 1);
    write_burst(27'h0000200, 8, 16'h0000, 0);
    for (int i = 0; i < 8; i++) exp_q.push_back({32'hB00C0000 + 32'(i), 96'h0} | 128'(i * 7 + 1));
    send_beat(CMD_READ, 27'h0000200, 6'd7, '0, '0);
    collect(8, 4'b1001, "bp");
  endtask

  // 3-beat write with idle gaps; state must stay WR until the last beat.
  task automatic test_write_gaps();
    logic [127:0] v [3] = '{128'hCAFE_0001, 128'hCAFE_0002, 128'hCAFE_0003};
    for (int i = 0; i < 3; i++) begin
      send_beat(CMD_WRITE, 27'h0000100, 6'd2, v[i], 16'h0000);
      if (i < 2) begin
        repeat (2) begin
          tick();
          total++;
          if (dut.state !== WR) begin
            bad++;
            $display("FAIL gaps_state_wr: state=%0d want %0d", dut.state, WR);
          end
        end
      end
    end
    total++;
    if (dut.state !== IDLE) begin
      bad++;
      $display("FAIL gaps_state_idle: state=%0d want %0d", dut.state, IDLE);
    end
    for (int i = 0; i < 3; i++) exp_q.push_back(v[i]);
    send_beat(CMD_READ, 27'h0000100, 6'd2, '0, '0);
    collect(3, 4'hF, "gaps");
  endtask

  // Reset pulsed while beat 2 of a 4-beat read is presented.
  task automatic test_reset_mid_read();
    int n = 0;
    logic [127:0] v [4] = '{128'h600D_0A, 128'h600D_0B, 128'h600D_0C, 128'h600D_0D};
    for (int i = 0; i < 4; i++) wbuf[i] = v[i];
    write_burst(27'h0000300, 4, 16'h0000, 0);
    send_beat(CMD_READ, 27'h0000300, 6'd3, '0, '0);
    while (io_fifo.rsp_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (io_fifo.rsp_data !== v[0]) begin
      bad++;
      $display("FAIL rstmid_beat0: data=%h want %h", io_fifo.rsp_data, v[0]);
    end
    io_fifo.rsp_ready = 1'b1;
    tick();
    io_fifo.rsp_ready = 1'b0;
    rst = 1'b1;
    tick();
    total++;
    if (io_fifo.rsp_valid !== 1'b0 || io_fifo.cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_in_reset: rsp_valid=%b cmd_ready=%b want 0/0", io_fifo.rsp_valid, io_fifo.cmd_ready);
    end
    rst = 1'b0;
    tick();
    total++;
    if (io_fifo.cmd_ready !== 1'b1 || io_fifo.rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_release: cmd_ready=%b rsp_valid=%b want 1/0", io_fifo.cmd_ready, io_fifo.rsp_valid);
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(v[i]);
    send_beat(CMD_READ, 27'h0000300, 6'd3, '0, '0);
    collect(4, 4'hF, "rstmid_after");
  endtask

  initial begin
    io_fifo.cmd_valid     = 1'b0;
    io_fifo.cmd_type      = CMD_READ;
    io_fifo.cmd_addr      = '0;
    io_fifo.cmd_burst_cnt = '0;
    io_fifo.cmd_wt_data   = '0;
    io_fifo.cmd_wt_mask   = '0;
    io_fifo.rsp_ready     = 1'b0;
    test_reset();
    test_single();
    test_burst_wrap();
    test_mask();
    test_backpressure();
    test_write_gaps();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
